// File: rtl/mem_load_unit_if.sv
// Bundle of the load-request, memory-read and response channels of mem_load_unit.
// The slave modport is the load unit; the master modport is its environment.
interface mem_load_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_op;
  logic [4:0]        req_rd;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic [4:0]        rsp_rd;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_addr, req_op, req_rd,
    input  mem_req_ready, mem_rvalid, mem_rdata,
    input  rsp_ready,
    output req_ready, mem_req_valid, mem_addr,
    output rsp_valid, rsp_data, rsp_rd, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_op, req_rd,
    output mem_req_ready, mem_rvalid, mem_rdata,
    output rsp_ready,
    input  req_ready, mem_req_valid, mem_addr,
    input  rsp_valid, rsp_data, rsp_rd, rsp_err
  );
endinterface

// File: rtl/mem_load_unit.sv
// Sequential load unit: one load at a time, split into up to two aligned word
// reads, then assembled and sign/zero-extended onto a valid/ready response.
module mem_load_unit #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  mem_load_unit_if.slave bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t            state_reg, state_next;
  logic [OFFW-1:0]   off_reg;
  logic [2:0]        op_reg;
  logic              cross_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [XLEN-1:0]   beat0_reg;
  logic [XLEN-1:0]   rsp_data_reg;
  logic [4:0]        rsp_rd_reg;
  logic              rsp_err_reg;

  logic [4:0]        span_in;
  logic              cross_in, illegal_in, reject_in;

  logic [XLEN-1:0]   asm_b0, asm_b1, keep_mask, sign_mask, asm_low, asm_result;
  logic [2*XLEN-1:0] asm_shift;
  logic              asm_neg;

  // Decode of the incoming request, used only in IDLE.
  always_comb begin
    span_in    = 5'(bus.req_addr[OFFW-1:0]) + (5'd1 << bus.req_op[1:0]);
    cross_in   = span_in > 5'(NB);
    illegal_in = (bus.req_op == 3'b111) ||
                 ((XLEN == 32) && (bus.req_op == 3'b011 || bus.req_op == 3'b110));
    reject_in  = illegal_in || (cross_in && !MISALIGN_EN);
  end

  // The arriving beat is taken straight from the bus so the result is ready on entry to RESP.
  always_comb begin
    asm_b0     = (state_reg == WAIT0) ? bus.mem_rdata : beat0_reg;
    asm_b1     = (state_reg == WAIT1) ? bus.mem_rdata : '0;
    asm_shift  = {asm_b1, asm_b0} >> {off_reg, 3'b000};
    keep_mask  = ~({XLEN{1'b1}} << (7'd8 << op_reg[1:0]));
    sign_mask  = keep_mask & ~(keep_mask >> 1);
    asm_low    = asm_shift[XLEN-1:0] & keep_mask;
    asm_neg    = !op_reg[2] && (|(asm_shift[XLEN-1:0] & sign_mask));
    asm_result = asm_low | (asm_neg ? ~keep_mask : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.req_valid)     state_next = reject_in ? RESP : REQ0;
      REQ0:    if (bus.mem_req_ready) state_next = WAIT0;
      WAIT0:   if (bus.mem_rvalid)    state_next = cross_reg ? REQ1 : RESP;
      REQ1:    if (bus.mem_req_ready) state_next = WAIT1;
      WAIT1:   if (bus.mem_rvalid)    state_next = RESP;
      RESP:    if (bus.rsp_ready)     state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      off_reg      <= '0;
      op_reg       <= '0;
      cross_reg    <= 1'b0;
      mem_addr_reg <= '0;
      beat0_reg    <= '0;
      rsp_data_reg <= '0;
      rsp_rd_reg   <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            off_reg      <= bus.req_addr[OFFW-1:0];
            op_reg       <= bus.req_op;
            cross_reg    <= cross_in;
            mem_addr_reg <= {bus.req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
            rsp_rd_reg   <= bus.req_rd;
            rsp_err_reg  <= reject_in;
            rsp_data_reg <= '0;
            beat0_reg    <= '0;
          end
        end
        WAIT0: begin
          if (bus.mem_rvalid) begin
            beat0_reg <= bus.mem_rdata;
            if (cross_reg) begin
              mem_addr_reg <= mem_addr_reg + ADDR_W'(NB);
            end else begin
              rsp_data_reg <= asm_result;
            end
          end
        end
        WAIT1: begin
          if (bus.mem_rvalid) begin
            rsp_data_reg <= asm_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready     = (state_reg == IDLE) && !rst;
  assign bus.mem_req_valid = (state_reg == REQ0) || (state_reg == REQ1);
  assign bus.mem_addr      = mem_addr_reg;
  assign bus.rsp_valid     = (state_reg == RESP);
  assign bus.rsp_data      = rsp_data_reg;
  assign bus.rsp_rd        = rsp_rd_reg;
  assign bus.rsp_err       = rsp_err_reg;
endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit (XLEN=32): unit A splits misaligned loads,
// unit B rejects them. A small memory responder serves unit A.
module tb_mem_load_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_load_unit_if #(.XLEN(32), .ADDR_W(32)) bus_a ();
  mem_load_unit_if #(.XLEN(32), .ADDR_W(32)) bus_b ();

  mem_load_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  mem_load_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h1000: return 32'h8899AABB;
      32'h1004: return 32'h11223344;
      default:  return 32'hDEADBEEF;
    endcase
  endfunction

  // Memory responder for unit A: acts 1 time unit after each rising edge.
  int          mem_stall = 0;
  bit          rv_hold   = 1'b0;
  int          stall_seen = 0;
  bit          pending   = 1'b0;
  logic [31:0] pend_addr;
  int          n_rd = 0;
  logic [31:0] rd_addr [16];

  always @(posedge clk) begin
    #1;
    bus_a.mem_rvalid = 1'b0;
    if (pending && !rv_hold) begin
      bus_a.mem_rvalid = 1'b1;
      bus_a.mem_rdata  = mem_word(pend_addr);
      pending          = 1'b0;
    end
    bus_a.mem_req_ready = (stall_seen >= mem_stall);
    if (bus_a.mem_req_valid) begin
      if (bus_a.mem_req_ready) begin
        pending           = 1'b1;
        pend_addr         = bus_a.mem_addr;
        rd_addr[n_rd % 16] = bus_a.mem_addr;
        n_rd++;
        stall_seen        = 0;
      end else begin
        stall_seen++;
      end
    end
  end

  logic rsp_ready_a = 1'b1;
  assign bus_a.rsp_ready = rsp_ready_a;

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] op,
                         input logic [4:0] rd, input logic [31:0] exp_data, input logic exp_err,
                         input int exp_lat, input int exp_nrd, input logic [31:0] exp_a1,
                         input int stall, input int hold);
    int          lat, start;
    bit          busy_ok, addr_ok, have_addr, hold_ok;
    logic [31:0] held_addr, held_data;
    mem_stall   = stall;
    rsp_ready_a = (hold == 0);
    @(negedge clk);
    chk({tag, ".req_ready_idle"}, bus_a.req_ready, 1'b1);
    start           = n_rd;
    bus_a.req_valid = 1'b1;
    bus_a.req_addr  = addr;
    bus_a.req_op    = op;
    bus_a.req_rd    = rd;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    bus_a.req_addr  = 32'h0;
    lat = 1; busy_ok = 1'b1; addr_ok = 1'b1; have_addr = 1'b0;
    held_addr = 32'h0;
    while (!bus_a.rsp_valid && lat < 40) begin
      if (bus_a.req_ready) busy_ok = 1'b0;
      if (bus_a.mem_req_valid) begin
        if (have_addr && bus_a.mem_addr !== held_addr) addr_ok = 1'b0;
        held_addr = bus_a.mem_addr;
        have_addr = 1'b1;
      end else begin
        have_addr = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    chk({tag, ".rsp_valid"}, bus_a.rsp_valid, 1'b1);
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".data"}, bus_a.rsp_data, exp_data);
    chk({tag, ".err"}, bus_a.rsp_err, exp_err);
    chk({tag, ".rd"}, bus_a.rsp_rd, rd);
    chk({tag, ".req_ready_busy"}, {busy_ok, bus_a.req_ready}, 2'b10);
    chk({tag, ".mem_addr_held"}, addr_ok, 1'b1);
    chk({tag, ".n_reads"}, n_rd - start, exp_nrd);
    if (exp_nrd >= 1) chk({tag, ".addr0"}, rd_addr[start % 16], {addr[31:2], 2'b00});
    if (exp_nrd >= 2) chk({tag, ".addr1"}, rd_addr[(start + 1) % 16], exp_a1);
    if (hold > 0) begin
      hold_ok   = 1'b1;
      held_data = bus_a.rsp_data;
      for (int i = 0; i < hold - 1; i++) begin
        @(negedge clk);
        if (!bus_a.rsp_valid || bus_a.rsp_data !== held_data || bus_a.req_ready) hold_ok = 1'b0;
      end
      chk({tag, ".rsp_hold"}, hold_ok, 1'b1);
      rsp_ready_a = 1'b1;
    end
    $display("load %s addr=0x%08h op=%0d rd=%0d -> data=0x%08h err=%0d lat=%0d reads=%0d",
             tag, addr, op, rd, bus_a.rsp_data, bus_a.rsp_err, lat, n_rd - start);
    @(negedge clk);
    chk({tag, ".single_rsp"}, bus_a.rsp_valid, 1'b0);
    chk({tag, ".req_ready_after"}, bus_a.req_ready, 1'b1);
    mem_stall = 0;
  endtask

  initial begin
    int guard;
    bus_a.req_valid = 1'b0; bus_a.req_addr = 32'h0; bus_a.req_op = 3'b0; bus_a.req_rd = 5'd0;
    bus_b.req_valid = 1'b0; bus_b.req_addr = 32'h0; bus_b.req_op = 3'b0; bus_b.req_rd = 5'd0;
    bus_b.mem_req_ready = 1'b1; bus_b.mem_rvalid = 1'b0; bus_b.mem_rdata = 32'h0;
    bus_b.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.req_ready", bus_a.req_ready, 1'b0);
    chk("reset.mem_req_valid", bus_a.mem_req_valid, 1'b0);
    chk("reset.rsp_valid", bus_a.rsp_valid, 1'b0);
    chk("reset.rsp_err", bus_a.rsp_err, 1'b0);
    chk("reset.rsp_data", bus_a.rsp_data, 32'h0);
    chk("reset.rsp_rd", bus_a.rsp_rd, 5'd0);
    chk("reset.mem_addr", bus_a.mem_addr, 32'h0);
    rst = 1'b0;

    do_load("lb",   32'h1001, 3'b000, 5'd7,  32'hFFFFFFAA, 1'b0, 3, 1, 32'h0, 0, 0);
    do_load("lbu",  32'h1003, 3'b100, 5'd2,  32'h00000088, 1'b0, 3, 1, 32'h0, 0, 0);
    do_load("lhu",  32'h1002, 3'b101, 5'd9,  32'h00008899, 1'b0, 3, 1, 32'h0, 0, 0);
    do_load("lw",   32'h1000, 3'b010, 5'd31, 32'h8899AABB, 1'b0, 3, 1, 32'h0, 0, 0);
    do_load("lh_split", 32'h1003, 3'b001, 5'd4, 32'h00004488, 1'b0, 5, 2, 32'h1004, 0, 0);
    do_load("ld_illegal",  32'h1000, 3'b011, 5'd5, 32'h0, 1'b1, 1, 0, 32'h0, 0, 0);
    do_load("lwu_illegal", 32'h1000, 3'b110, 5'd6, 32'h0, 1'b1, 1, 0, 32'h0, 0, 0);
    do_load("op7_illegal", 32'h1004, 3'b111, 5'd8, 32'h0, 1'b1, 1, 0, 32'h0, 0, 0);
    do_load("backpressure", 32'h1004, 3'b001, 5'd11, 32'h00003344, 1'b0, 6, 1, 32'h0, 3, 4);

    // Unit B refuses misaligned accesses without touching memory.
    @(negedge clk);
    bus_b.req_valid = 1'b1; bus_b.req_addr = 32'h1002; bus_b.req_op = 3'b010; bus_b.req_rd = 5'd3;
    @(negedge clk);
    bus_b.req_valid = 1'b0;
    chk("noalign.rsp_valid", bus_b.rsp_valid, 1'b1);
    chk("noalign.err", bus_b.rsp_err, 1'b1);
    chk("noalign.data", bus_b.rsp_data, 32'h0);
    chk("noalign.rd", bus_b.rsp_rd, 5'd3);
    chk("noalign.mem_req_valid", bus_b.mem_req_valid, 1'b0);
    $display("load noalign addr=0x00001002 op=2 rd=3 -> data=0x%08h err=%0d",
             bus_b.rsp_data, bus_b.rsp_err);
    @(negedge clk);
    chk("noalign.done", {bus_b.rsp_valid, bus_b.req_ready}, 2'b01);

    // Reset in WAIT1 of a split LW, then a stray read beat.
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_addr = 32'h1002; bus_a.req_op = 3'b010; bus_a.req_rd = 5'd12;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    guard = 0;
    while (!(bus_a.mem_req_valid && bus_a.mem_addr == 32'h1004) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("rstmid.reached_req1", guard < 20, 1'b1);
    rv_hold = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.req_ready_in_rst", bus_a.req_ready, 1'b0);
    chk("rstmid.rsp_valid_in_rst", bus_a.rsp_valid, 1'b0);
    rst = 1'b0;
    rv_hold = 1'b0;
    @(negedge clk);
    chk("rstmid.req_ready", bus_a.req_ready, 1'b1);
    chk("rstmid.stray_ignored", {bus_a.rsp_valid, bus_a.mem_req_valid}, 2'b00);
    @(negedge clk);
    chk("rstmid.still_idle", {bus_a.rsp_valid, bus_a.req_ready}, 2'b01);
    $display("load rstmid addr=0x00001002 op=2 rd=12 -> dropped by reset");
    do_load("lw_after_rst", 32'h1004, 3'b010, 5'd13, 32'h11223344, 1'b0, 3, 1, 32'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
